// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one single-port memory between instruction fetch and data access.
// The data side always wins. Each access waits for an ack, with a watchdog, and ends with a one-cycle ready pulse.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              timeout_err
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             dm_req;
    logic             acc_end;

    assign dm_req  = dm_read | dm_write;
    assign stall   = (if_req & ~if_ready) | (dm_req & ~dm_ready);
    // An access ends on ack, or when the cycle about to reach MAX_WAIT still has no ack.
    assign acc_end = mem_ack | (wait_cnt == WAIT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            if_rdata    <= '0;
            dm_rdata    <= '0;
            if_ready    <= 1'b0;
            dm_ready    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dm_req) begin
                        state     <= DM_ACC;
                        mem_en    <= 1'b1;
                        mem_we    <= dm_write;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                    end else if (if_req) begin
                        state    <= IF_ACC;
                        mem_en   <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                    end
                end
                IF_ACC, DM_ACC: begin
                    if (acc_end) begin
                        state    <= DONE;
                        wait_cnt <= '0;
                        mem_en   <= 1'b0;
                        mem_we   <= 1'b0;
                        if (!mem_ack) timeout_err <= 1'b1;
                        if (state == IF_ACC) begin
                            if_ready <= 1'b1;
                            if_rdata <= mem_ack ? mem_rdata : '0;
                        end else begin
                            dm_ready <= 1'b1;
                            // A write ack leaves the load register untouched; a timeout zeroes it.
                            if (!mem_ack)     dm_rdata <= '0;
                            else if (!mem_we) dm_rdata <= mem_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if_ready <= 1'b0;
                    dm_ready <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed requests with a scripted memory responder.
// Scoreboard queues hold the expected memory accesses and ready responses.
module tb_mem_port_arbiter;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              dm_read = 1'b0;
    logic              dm_write = 1'b0;
    logic [ADDR_W-1:0] dm_addr = '0;
    logic [DATA_W-1:0] dm_wdata = '0;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;
    logic              stall;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ack = 1'b0;
    logic              timeout_err;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready), .stall(stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;  // mem_en cycles before ack; -1 = never ack
        int          len;    // expected number of mem_en cycles
    } acc_t;

    typedef struct {
        logic        is_dm;
        logic [31:0] rdata;
    } rdy_t;

    acc_t acc_q[$];
    rdy_t rdy_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_acc(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int delay, input int len);
        acc_t a;
        a.we = we; a.addr = addr; a.wdata = wdata; a.rdata = rdata; a.delay = delay; a.len = len;
        acc_q.push_back(a);
    endtask

    task automatic push_rdy(input logic is_dm, input logic [31:0] rdata);
        rdy_t r;
        r.is_dm = is_dm; r.rdata = rdata;
        rdy_q.push_back(r);
    endtask

    // Waits for the selected ready pulse; stall must be high on every cycle before it.
    task automatic wait_ready(input logic is_dm, input int exp_lat, input string name);
        int  n = 0;
        bit  seen = 0;
        while (!seen && n < 50) begin
            @(negedge clock);
            n++;
            if (is_dm ? dm_ready : if_ready) seen = 1;
            else check({name, "_stall"}, 32'(stall), 32'd1);
        end
        check({name, "_latency"}, 32'(n), 32'(exp_lat));
    endtask

    // Memory responder and access monitor.
    acc_t cur;
    bit   have_cur = 0;
    int   en_cnt = 0;
    always @(negedge clock) begin
        if (!reset) begin
            en_cnt = 0; have_cur = 0; mem_ack = 1'b0;
        end else if (mem_en) begin
            if (en_cnt == 0) begin
                if (acc_q.size() == 0) begin
                    checks++; errors++; have_cur = 0;
                    $display("FAIL unexpected_access: addr 0x%08h we %0b, none expected", mem_addr, mem_we);
                end else begin
                    cur = acc_q.pop_front();
                    have_cur = 1;
                end
            end
            if (have_cur) begin
                check("mem_we", 32'(mem_we), 32'(cur.we));
                check("mem_addr", mem_addr, cur.addr);
                if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
            end
            mem_ack   = have_cur && cur.delay >= 0 && en_cnt == cur.delay;
            mem_rdata = have_cur ? cur.rdata : 32'h0;
            en_cnt++;
        end else begin
            if (en_cnt > 0 && have_cur) check("mem_en_cycles", 32'(en_cnt), 32'(cur.len));
            en_cnt = 0; have_cur = 0; mem_ack = 1'b0;
        end
    end

    // Ready monitor.
    always @(negedge clock) begin
        if (reset && (if_ready || dm_ready)) begin
            rdy_t e;
            if (if_ready && dm_ready) begin
                checks++; errors++;
                $display("FAIL both_ready: if_ready and dm_ready both 1, at most one expected");
            end
            if (rdy_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ready: if_ready %0b dm_ready %0b, none expected", if_ready, dm_ready);
            end else begin
                e = rdy_q.pop_front();
                check("ready_source_dm", 32'(dm_ready), 32'(e.is_dm));
                if (e.is_dm) check("dm_rdata", dm_rdata, e.rdata);
                else         check("if_rdata", if_rdata, e.rdata);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        repeat (2) @(negedge clock);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_ready", 32'({if_ready, dm_ready}), 32'd0);
        check("rst_rdata", if_rdata | dm_rdata, 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("idle_mem_en", 32'(mem_en), 32'd0);
        end

        // Fetch with ack two cycles after mem_en.
        push_acc(1'b0, 32'h40, 32'h0, 32'h8C010004, 2, 3);
        push_rdy(1'b0, 32'h8C010004);
        if_req = 1'b1; if_addr = 32'h40;
        wait_ready(1'b0, 4, "if_fetch");
        @(negedge clock); if_req = 1'b0;

        // Simultaneous fetch and load: load first, then fetch.
        push_acc(1'b0, 32'h100, 32'h0, 32'h11112222, 1, 2);
        push_acc(1'b0, 32'h44, 32'h0, 32'h33334444, 0, 1);
        push_rdy(1'b1, 32'h11112222);
        push_rdy(1'b0, 32'h33334444);
        if_req = 1'b1; if_addr = 32'h44; dm_read = 1'b1; dm_addr = 32'h100;
        wait_ready(1'b1, 3, "dm_first");
        @(negedge clock); dm_read = 1'b0;
        wait_ready(1'b0, 2, "if_second");
        check("stall_clear", 32'(stall), 32'd0);
        @(negedge clock); if_req = 1'b0;

        // Store with immediate ack; request held across the DONE exit edge.
        push_acc(1'b1, 32'h200, 32'hDEADBEEF, 32'h5555AAAA, 0, 1);
        push_rdy(1'b1, 32'h11112222);
        dm_write = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF;
        wait_ready(1'b1, 2, "dm_write");
        @(negedge clock); dm_write = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("no_reissue", 32'(mem_en), 32'd0);
        end

        // Ack on the last cycle before the watchdog fires.
        push_acc(1'b0, 32'h300, 32'h0, 32'h12345678, MAX_WAIT - 1, MAX_WAIT);
        push_rdy(1'b1, 32'h12345678);
        dm_read = 1'b1; dm_addr = 32'h300;
        wait_ready(1'b1, MAX_WAIT + 1, "dm_late_ack");
        check("late_ack_no_timeout", 32'(timeout_err), 32'd0);
        @(negedge clock); dm_read = 1'b0;

        // Watchdog: no ack at all.
        push_acc(1'b0, 32'h3FC, 32'h0, 32'h77777777, -1, MAX_WAIT);
        push_rdy(1'b1, 32'h0);
        dm_read = 1'b1; dm_addr = 32'h3FC;
        wait_ready(1'b1, MAX_WAIT + 1, "dm_timeout");
        check("timeout_err_set", 32'(timeout_err), 32'd1);
        @(negedge clock); dm_read = 1'b0;
        repeat (3) @(negedge clock);
        check("timeout_err_sticky", 32'(timeout_err), 32'd1);

        // Reset during a fetch access, then re-serve the held fetch.
        push_acc(1'b0, 32'h80, 32'h0, 32'h0, -1, 0);
        if_req = 1'b1; if_addr = 32'h80;
        repeat (2) @(negedge clock);
        check("pre_reset_mem_en", 32'(mem_en), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_mem_en", 32'(mem_en), 32'd0);
        check("async_rst_mem_addr", mem_addr, 32'd0);
        check("async_rst_if_rdata", if_rdata, 32'd0);
        check("async_rst_timeout_err", 32'(timeout_err), 32'd0);
        repeat (2) begin
            @(negedge clock);
            check("reset_no_ready", 32'(if_ready), 32'd0);
        end
        push_acc(1'b0, 32'h80, 32'h0, 32'hCAFEF00D, 1, 2);
        push_rdy(1'b0, 32'hCAFEF00D);
        reset = 1'b1;
        wait_ready(1'b0, 3, "if_after_reset");
        @(negedge clock); if_req = 1'b0;

        repeat (4) @(negedge clock);
        check("acc_q_empty", 32'(acc_q.size()), 32'd0);
        check("rdy_q_empty", 32'(rdy_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
